irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller for the embedded SoC peripheral bus.
- Collects interrupt lines from the timer and other peripherals.
- Latches each line as pending, prioritises the pending lines, and presents a single ext_int to the core.
- Sequences service with a claim/complete handshake, one source in service at a time.
- Sits on the same mem_we / mem_addr / mem_data tri-state bus as the other peripherals.

Parameters:
- NSRC, 4, number of interrupt sources (1..31); source 0 is the timer by convention.
- BASE, 32'hffff0040, register block base address; register address = BASE | offset.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- mem_we  input  1  bus write strobe
- mem_addr  input  32  bus address
- mem_data  inout  32  bus data; driven only on a read hit, else 'bz
- src_irq  input  NSRC  raw interrupt lines from peripherals
- ext_int  output  1  interrupt request to core
- in_service  output  1  high while a claimed source awaits completion
- active_id  output  5  id (index+1) of the source in service; 0 when none

Behaviour:
- Clock and reset:
  - All state updates on posedge clk.
  - rst=0 resets, at the next edge: pending=0, enable=0, prev_irq=0, state=IDLE, active_id=0.
  - Outputs during and after reset: ext_int=0, in_service=0, mem_data=z.
- Register map:
  - 0x0 PEND: RO, bits[NSRC-1:0] pending, upper bits 0.
  - 0x4 ENABLE: RW, bits[NSRC-1:0]; writes to upper bits ignored.
  - 0x8 CLAIM: read returns best_id, no side effect. Write value k claims source k-1.
  - 0xC COMPLETE: write value k completes source k-1. Reads return 0.
- Bus reads:
  - Combinational.
  - mem_data driven when rst=1, mem_we=0 and mem_addr matches a register; otherwise 'bz.
- Bus writes: take effect at the clock edge where mem_we=1 and mem_addr matches.
- Edge capture:
  - prev_irq <= src_irq every cycle.
  - Pending bit i sets on src_irq[i] & ~prev_irq[i], regardless of enable.
  - A high source at reset release pends one cycle after rst rises.
- best_id:
  - Lowest index i with pending[i]&enable[i], returned as i+1.
  - 0 if none; fixed priority, index 0 highest.
- ext_int = (state==IDLE) && (best_id!=0). Registered-input combinational, so it rises one cycle after the qualifying edge.
- FSM IDLE:
  - Write CLAIM k with 1<=k<=NSRC and pending[k-1]=1: clear pending[k-1], active_id<=k, go to SERVICE.
  - Enable is not required to claim.
  - Other CLAIM values are ignored and the state stays IDLE.
  - COMPLETE writes are ignored.
- FSM SERVICE:
  - ext_int is held 0.
  - CLAIM writes are ignored; no nesting.
  - Write COMPLETE k == active_id: active_id<=0, go to IDLE. Any other COMPLETE value is ignored.
- Simultaneous events:
  - New edge on a source in the same cycle its pending is cleared by claim: set wins, pending stays 1.
  - A re-edge on the in-service source during SERVICE re-pends it, giving one queued occurrence; further edges are absorbed.
- ENABLE write concurrent with an edge: both apply.
- Reset mid-SERVICE: returns to IDLE with all pending lost; the core must re-initialise.
- Width rule: claim/complete values are compared on the full 32-bit word, so k>NSRC or k=0 never matches.

Optional Feature:
- Macro: IRQ_CTRL_LEVEL_EN.
- Defined:
  - Adds register 0x10 TRIG: RW, bits[NSRC-1:0], reset 0.
  - TRIG[i]=1 makes source i level-sensitive: pending[i] is set every cycle src_irq[i]=1.
  - A claim clears the bit only if the line is low in that cycle; otherwise the bit remains set after claim.
  - TRIG[i]=0 keeps edge behaviour.
- Undefined:
  - No TRIG register; address 0x10 is not decoded and mem_data stays 'bz.
  - All sources are edge-triggered.

Test Plan:
- Reset/read:
  - Stimulus: hold rst=0 for 3 cycles, release, then read 0x0, 0x4, 0x8.
  - Response: all read 0, ext_int=0; read of BASE|0x14 leaves mem_data=z.
- Single source:
  - Stimulus: write ENABLE=4'b0001; pulse src_irq[0] for 1 cycle.
  - Response: PEND=1 and ext_int=1 one cycle after the edge; CLAIM read=1.
  - Stimulus: write CLAIM=1.
  - Response: PEND=0, ext_int=0, in_service=1, active_id=1.
  - Stimulus: write COMPLETE=1.
  - Response: in_service=0.
- Priority:
  - Stimulus: ENABLE=4'b1100; edges on src 2 and 3 in the same cycle.
  - Response: CLAIM read=3.
  - Stimulus: claim 3, then complete 3.
  - Response: ext_int re-asserts in the next cycle; CLAIM read=4.
- Guards:
  - Stimulus: in SERVICE with id 1, write CLAIM=2, then COMPLETE=3, then CLAIM=0 and CLAIM=7 (NSRC=4).
  - Response: state, pending and active_id unchanged.
- Race:
  - Stimulus: edge on src 1 in the same cycle as CLAIM=2 is written.
  - Response: pending[1] remains 1.
  - Stimulus: during SERVICE, 3 further edges on src 1.
  - Response: exactly one pending; after COMPLETE, ext_int=1.
- Level mode (IRQ_CTRL_LEVEL_EN):
  - Stimulus: TRIG=1, src_irq[0] held high, CLAIM=1, COMPLETE=1.
  - Response: ext_int=1 again immediately after completion.
  - Stimulus: drop the line to 0, then claim again.
  - Response: pending clears.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing interrupt controller with claim/complete service.
// Define IRQ_CTRL_LEVEL_EN to add the TRIG register (per-source level mode).
module irq_ctrl #(
  parameter int          NSRC = 4,
  parameter logic [31:0] BASE = 32'hffff0040
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_we,
  input  logic [31:0]     mem_addr,
  inout  wire  [31:0]     mem_data,
  input  logic [NSRC-1:0] src_irq,
  output logic            ext_int,
  output logic            in_service,
  output logic [4:0]      active_id
);

  typedef enum logic {
    IDLE,
    SERVICE
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] prev_q, prev_d;
  logic [4:0]      aid_q, aid_d;
  logic [NSRC-1:0] set;
  logic [4:0]      best_id;
  logic [31:0]     rd_data;
  logic            rd_hit;
  logic            hit_pend, hit_en, hit_claim, hit_comp;
  logic            wr_en, wr_claim, wr_comp;

  assign hit_pend  = mem_addr == (BASE | 32'h0);
  assign hit_en    = mem_addr == (BASE | 32'h4);
  assign hit_claim = mem_addr == (BASE | 32'h8);
  assign hit_comp  = mem_addr == (BASE | 32'hc);

  assign wr_en    = mem_we & hit_en;
  assign wr_claim = mem_we & hit_claim;
  assign wr_comp  = mem_we & hit_comp;

`ifdef IRQ_CTRL_LEVEL_EN
  logic [NSRC-1:0] trig_q, trig_d;
  logic            hit_trig;

  assign hit_trig = mem_addr == (BASE | 32'h10);
  // level sources re-pend every cycle the line is high, so set beats claim
  assign set = (trig_q & src_irq) | (~trig_q & src_irq & ~prev_q);
`else
  assign set = src_irq & ~prev_q;
`endif

  always_comb begin
    best_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_q[i] & en_q[i]) best_id = 5'(i + 1);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    unique case (1'b1)
      hit_pend:  begin rd_hit = 1'b1; rd_data = 32'(pend_q); end
      hit_en:    begin rd_hit = 1'b1; rd_data = 32'(en_q); end
      hit_claim: begin rd_hit = 1'b1; rd_data = 32'(best_id); end
      hit_comp:  begin rd_hit = 1'b1; rd_data = '0; end
`ifdef IRQ_CTRL_LEVEL_EN
      hit_trig:  begin rd_hit = 1'b1; rd_data = 32'(trig_q); end
`endif
      default: ;
    endcase
  end

  assign mem_data = (rst & ~mem_we & rd_hit) ? rd_data : 'z;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    en_d    = en_q;
    aid_d   = aid_q;
    prev_d  = src_irq;
    if (wr_en) en_d = mem_data[NSRC-1:0];
    unique case (state_q)
      IDLE: begin
        if (wr_claim) begin
          for (int i = 0; i < NSRC; i++) begin
            if (mem_data == 32'(i + 1) && pend_q[i]) begin
              pend_d[i] = 1'b0;
              aid_d     = 5'(i + 1);
              state_d   = SERVICE;
            end
          end
        end
      end
      SERVICE: begin
        if (wr_comp && mem_data == 32'(aid_q)) begin
          aid_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = pend_d | set;
  end

`ifdef IRQ_CTRL_LEVEL_EN
  always_comb begin
    trig_d = trig_q;
    if (mem_we && hit_trig) trig_d = mem_data[NSRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) trig_q <= '0;
    else      trig_q <= trig_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      en_q    <= '0;
      prev_q  <= '0;
      aid_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      prev_q  <= prev_d;
      aid_q   <= aid_d;
    end
  end

  assign in_service = rst && state_q == SERVICE;
  assign ext_int    = rst && state_q == IDLE && best_id != 5'd0;
  assign active_id  = rst ? aid_q : 5'd0;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: vector table for irq_ctrl, expectations queued per cycle
// and compared at the falling edge against the design outputs.
module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'hffff0040;
  localparam logic [31:0] Z    = 32'hffff_ffff;

  logic        clk;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] tb_data;
  logic        tb_drive;
  logic [3:0]  src_irq;
  logic        ext_int;
  logic        in_service;
  logic [4:0]  active_id;
  tri1  [31:0] mem_data;

  assign mem_data = tb_drive ? tb_data : 'z;

  irq_ctrl #(.NSRC(4), .BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .src_irq   (src_irq),
    .ext_int   (ext_int),
    .in_service(in_service),
    .active_id (active_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          r;
    bit          we;
    bit          rd;
    logic [7:0]  off;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] erd;
    logic        ext;
    logic        isv;
    logic [4:0]  aid;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic add(bit r, bit we, bit rd, logic [7:0] off,
                     logic [31:0] d, logic [3:0] s, logic [31:0] erd,
                     logic ext, logic isv, logic [4:0] aid, string nm);
    vec_t v;
    v.r = r; v.we = we; v.rd = rd; v.off = off; v.d = d; v.s = s;
    v.erd = erd; v.ext = ext; v.isv = isv; v.aid = aid; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic t_rd(logic [7:0] off, logic [31:0] erd, logic [3:0] s,
                      logic ext, logic isv, logic [4:0] aid, string nm);
    add(1, 0, 1, off, 0, s, erd, ext, isv, aid, nm);
  endtask

  task automatic t_wr(logic [7:0] off, logic [31:0] d, logic [3:0] s,
                      logic ext, logic isv, logic [4:0] aid, string nm);
    add(1, 1, 0, off, d, s, 0, ext, isv, aid, nm);
  endtask

  task automatic t_nop(logic [3:0] s, logic ext, logic isv,
                       logic [4:0] aid, string nm);
    add(1, 0, 0, 0, 0, s, 0, ext, isv, aid, nm);
  endtask

  task automatic step(vec_t v);
    @(posedge clk);
    #1;
    rst      = v.r;
    src_irq  = v.s;
    mem_we   = v.we;
    mem_addr = (v.we || v.rd) ? (BASE | 32'(v.off)) : 32'h0;
    tb_drive = v.we;
    tb_data  = v.d;
    sb.push_back(v);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m = sb.pop_front();
      chk({m.nm, "/ext"}, 32'(ext_int), 32'(m.ext));
      chk({m.nm, "/isv"}, 32'(in_service), 32'(m.isv));
      chk({m.nm, "/aid"}, 32'(active_id), 32'(m.aid));
      if (m.rd) chk({m.nm, "/rd"}, mem_data, m.erd);
    end
  end

  initial begin
    rst      = 1'b0;
    mem_we   = 1'b0;
    mem_addr = BASE;
    tb_drive = 1'b0;
    tb_data  = '0;
    src_irq  = '0;

    // reset held for three edges: outputs quiet, bus not driven
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ext", 32'(ext_int), 0);
      chk("hold_isv", 32'(in_service), 0);
      chk("hold_z", mem_data, Z);
    end

    t_rd(8'h00, 0, 4'h0, 0, 0, 0, "rst_pend");
    t_rd(8'h04, 0, 4'h0, 0, 0, 0, "rst_en");
    t_rd(8'h08, 0, 4'h0, 0, 0, 0, "rst_claim");
    t_rd(8'h0c, 0, 4'h0, 0, 0, 0, "comp_rd");
    t_rd(8'h14, Z, 4'h0, 0, 0, 0, "unmapped14");
`ifdef IRQ_CTRL_LEVEL_EN
    t_rd(8'h10, 0, 4'h0, 0, 0, 0, "trig_rst");
`else
    t_rd(8'h10, Z, 4'h0, 0, 0, 0, "no_trig");
`endif
    t_wr(8'h04, 1, 4'h0, 0, 0, 0, "en1");
    t_nop(4'h1, 0, 0, 0, "edge0");
    t_rd(8'h00, 1, 4'h0, 1, 0, 0, "pend0");
    t_rd(8'h08, 1, 4'h0, 1, 0, 0, "best1");
    t_wr(8'h08, 1, 4'h0, 1, 0, 0, "claim1");
    t_rd(8'h00, 0, 4'h0, 0, 1, 1, "pend_clr");
    t_wr(8'h0c, 1, 4'h0, 0, 1, 1, "comp1");
    t_rd(8'h0c, 0, 4'h0, 0, 0, 0, "idle_again");

    t_wr(8'h04, 4'hc, 4'h0, 0, 0, 0, "en_c");
    t_nop(4'hc, 0, 0, 0, "edge23");
    t_rd(8'h08, 3, 4'h0, 1, 0, 0, "prio3");
    t_rd(8'h00, 4'hc, 4'h0, 1, 0, 0, "pend23");
    t_wr(8'h08, 3, 4'h0, 1, 0, 0, "claim3");
    t_rd(8'h08, 4, 4'h0, 0, 1, 3, "best4_svc");
    t_wr(8'h0c, 3, 4'h0, 0, 1, 3, "comp3");
    t_rd(8'h08, 4, 4'h0, 1, 0, 0, "reassert");
    t_wr(8'h08, 4, 4'h0, 1, 0, 0, "claim4");
    t_wr(8'h0c, 4, 4'h0, 0, 1, 4, "comp4");
    t_rd(8'h00, 0, 4'h0, 0, 0, 0, "empty");

    t_wr(8'h04, 4'hf, 4'h3, 0, 0, 0, "en_edge");
    t_rd(8'h00, 3, 4'h0, 1, 0, 0, "pend01");
    t_rd(8'h04, 4'hf, 4'h0, 1, 0, 0, "en_f");
    t_wr(8'h08, 1, 4'h0, 1, 0, 0, "g_claim1");
    t_wr(8'h08, 2, 4'h0, 0, 1, 1, "g_claim2");
    t_wr(8'h0c, 3, 4'h0, 0, 1, 1, "g_comp3");
    t_wr(8'h08, 0, 4'h0, 0, 1, 1, "g_claim0");
    t_wr(8'h08, 7, 4'h0, 0, 1, 1, "g_claim7");
    t_rd(8'h00, 2, 4'h0, 0, 1, 1, "g_pend");
    t_wr(8'h0c, 32'h21, 4'h0, 0, 1, 1, "g_comp33");
    t_wr(8'h0c, 1, 4'h0, 0, 1, 1, "g_comp1");
    t_rd(8'h08, 2, 4'h0, 1, 0, 0, "g_idle");
    t_wr(8'h08, 3, 4'h0, 1, 0, 0, "claim_np");
    t_wr(8'h0c, 2, 4'h0, 1, 0, 0, "comp_idle");
    t_rd(8'h00, 2, 4'h0, 1, 0, 0, "g_pend2");

    t_wr(8'h08, 2, 4'h2, 1, 0, 0, "race_claim");
    t_rd(8'h00, 2, 4'h2, 0, 1, 2, "race_pend");
    t_nop(4'h0, 0, 1, 2, "t0");
    t_nop(4'h2, 0, 1, 2, "t1");
    t_nop(4'h0, 0, 1, 2, "t2");
    t_nop(4'h2, 0, 1, 2, "t3");
    t_nop(4'h0, 0, 1, 2, "t4");
    t_nop(4'h2, 0, 1, 2, "t5");
    t_nop(4'h0, 0, 1, 2, "t6");
    t_rd(8'h00, 2, 4'h0, 0, 1, 2, "one_pend");
    t_wr(8'h0c, 2, 4'h0, 0, 1, 2, "race_comp");
    t_rd(8'h08, 2, 4'h0, 1, 0, 0, "requeue");
    t_wr(8'h08, 2, 4'h0, 1, 0, 0, "reclaim");
    t_rd(8'h00, 0, 4'h0, 0, 1, 2, "absorbed");
    t_wr(8'h0c, 2, 4'h0, 0, 1, 2, "race_done");
    t_rd(8'h00, 0, 4'h0, 0, 0, 0, "quiet");

`ifdef IRQ_CTRL_LEVEL_EN
    t_wr(8'h10, 1, 4'h0, 0, 0, 0, "trig_wr");
    t_rd(8'h10, 1, 4'h1, 0, 0, 0, "trig_rd");
    t_rd(8'h00, 1, 4'h1, 1, 0, 0, "lvl_pend");
    t_wr(8'h08, 1, 4'h1, 1, 0, 0, "lvl_claim");
    t_rd(8'h00, 1, 4'h1, 0, 1, 1, "lvl_stay");
    t_wr(8'h0c, 1, 4'h1, 0, 1, 1, "lvl_comp");
    t_rd(8'h08, 1, 4'h1, 1, 0, 0, "lvl_again");
    t_nop(4'h0, 1, 0, 0, "lvl_drop");
    t_wr(8'h08, 1, 4'h0, 1, 0, 0, "lvl_claim2");
    t_rd(8'h00, 0, 4'h0, 0, 1, 1, "lvl_clr");
    t_wr(8'h0c, 1, 4'h0, 0, 1, 1, "lvl_comp2");
    t_rd(8'h00, 0, 4'h0, 0, 0, 0, "lvl_quiet");
`else
    t_wr(8'h10, 1, 4'h0, 0, 0, 0, "trig_ign");
    t_nop(4'h1, 0, 0, 0, "e_edge");
    t_rd(8'h00, 1, 4'h1, 1, 0, 0, "e_pend");
    t_wr(8'h08, 1, 4'h1, 1, 0, 0, "e_claim");
    t_rd(8'h00, 0, 4'h1, 0, 1, 1, "e_clr");
    t_wr(8'h0c, 1, 4'h1, 0, 1, 1, "e_comp");
    t_rd(8'h00, 0, 4'h0, 0, 0, 0, "e_quiet");
`endif

    // reset while a source is in service, line held high across release
    t_nop(4'h4, 0, 0, 0, "m_edge");
    t_wr(8'h08, 3, 4'h4, 1, 0, 0, "m_claim");
    add(0, 0, 1, 8'h00, 0, 4'h4, Z, 0, 0, 0, "m_rst_a");
    add(0, 0, 1, 8'h04, 0, 4'h4, Z, 0, 0, 0, "m_rst_b");
    t_rd(8'h00, 0, 4'h4, 0, 0, 0, "m_rel");
    t_rd(8'h00, 4, 4'h4, 0, 0, 0, "m_late_pend");
    t_rd(8'h04, 0, 4'h4, 0, 0, 0, "m_en_lost");

    foreach (tbl[i]) step(tbl[i]);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d queued want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
